// File: rtl/sample_framer.sv
// Drains a first-word-fall-through sample queue into SYNC / ID / sample byte frames for the UART TX queue.
// Define SAMPLE_FRAMER_CSUM_EN to append an XOR checksum byte (ID through last sample byte) to every frame.
module sample_framer #(
  parameter int unsigned NBITS = 12,
  parameter int unsigned NSAMP = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       ch_id,
  input  logic [NBITS-1:0] s_out,
  input  logic             s_em,
  output logic             s_pp,
  input  logic             tx_full,
  output logic [7:0]       tx_byte,
  output logic             tx_ld,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_ID, ST_FETCH, ST_SHI, ST_SLO, ST_CSUM
  } state_t;

  state_t        state, state_d;
  logic [3:0]    seq, seq_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [15:0]   smp, smp_d;
  logic [7:0]    byte_d;
  logic          ld_d, pp_d, busy_d, done_d;
  logic          fin;
`ifdef SAMPLE_FRAMER_CSUM_EN
  logic [7:0]    csum, csum_d;
`endif

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state;
    seq_d   = seq;
    cnt_d   = cnt;
    smp_d   = smp;
    byte_d  = tx_byte;
    ld_d    = 1'b0;
    pp_d    = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef SAMPLE_FRAMER_CSUM_EN
    csum_d  = csum;
`endif
    case (state)
      // frame_done is high in the first IDLE cycle; blocking a start there forces the idle gap
      ST_IDLE: begin
        busy_d = 1'b0;
        if (en && !s_em && !frame_done) begin
          state_d = ST_SYNC;
          busy_d  = 1'b1;
        end
      end
      ST_SYNC: if (!tx_full) begin
        byte_d  = SYNC;
        ld_d    = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: if (!tx_full) begin
        byte_d  = {ch_id, seq};
        ld_d    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: if (!s_em) begin
        smp_d   = 16'(s_out);
        pp_d    = 1'b1;
        state_d = ST_SHI;
      end
      ST_SHI: if (!tx_full) begin
        byte_d  = smp[15:8];
        ld_d    = 1'b1;
        state_d = ST_SLO;
      end
      ST_SLO: if (!tx_full) begin
        byte_d = smp[7:0];
        ld_d   = 1'b1;
        cnt_d  = cnt + CW'(1);
        if (cnt_d < LAST_CNT) state_d = ST_FETCH;
`ifdef SAMPLE_FRAMER_CSUM_EN
        else state_d = ST_CSUM;
`else
        else fin = 1'b1;
`endif
      end
`ifdef SAMPLE_FRAMER_CSUM_EN
      ST_CSUM: if (!tx_full) begin
        byte_d = csum;
        ld_d   = 1'b1;
        fin    = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      seq_d   = seq + 4'd1;
      cnt_d   = '0;
    end

`ifdef SAMPLE_FRAMER_CSUM_EN
    // Fold ID and sample bytes only; SYNC and the checksum byte itself are excluded
    if (state == ST_IDLE && state_d == ST_SYNC) csum_d = '0;
    else if (ld_d && state != ST_SYNC && state != ST_CSUM) csum_d = csum ^ byte_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      seq        <= '0;
      cnt        <= '0;
      smp        <= '0;
      tx_byte    <= 8'h00;
      tx_ld      <= 1'b0;
      s_pp       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SAMPLE_FRAMER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
      seq        <= seq_d;
      cnt        <= cnt_d;
      smp        <= smp_d;
      tx_byte    <= byte_d;
      tx_ld      <= ld_d;
      s_pp       <= pp_d;
      busy       <= busy_d;
      frame_done <= done_d;
`ifdef SAMPLE_FRAMER_CSUM_EN
      csum       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: a frame-level reference model fills an expected-byte queue,
// a negedge monitor pops and compares every loaded byte along with strobe/busy/pop behaviour.
module tb_sample_framer;

  localparam int unsigned NBITS = 12;
  localparam int unsigned NSAMP = 2;
  localparam logic [7:0]  SYNC  = 8'hA5;
`ifdef SAMPLE_FRAMER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [3:0]       ch_id = 4'd0;
  logic [NBITS-1:0] s_out = '0;
  logic             s_em = 1'b1;
  logic             s_pp;
  logic             tx_full = 1'b0;
  logic [7:0]       tx_byte;
  logic             tx_ld;
  logic             busy;
  logic             frame_done;

  sample_framer #(.NBITS(NBITS), .NSAMP(NSAMP), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_id(ch_id), .s_out(s_out), .s_em(s_em),
    .s_pp(s_pp), .tx_full(tx_full), .tx_byte(tx_byte), .tx_ld(tx_ld),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected entries: {first_of_frame, last_of_frame, byte}
  logic [NBITS-1:0] src_q[$];
  logic [9:0]       exp_q[$];
  logic [NBITS-1:0] stim[NSAMP];
  logic [3:0]       m_seq = 4'd0;
  bit               force_full = 1'b0;
  int               bp_mode = 0;
  int               vectors = 0;
  int               miscompares = 0;
  int               to_cnt = 0;
  int               to_seen = 0;
  bit               end_req = 1'b0;
  bit               end_done = 1'b0;
  bit               full_seen = 1'b0;
  int               pops = 0;
  bit               in_frame = 1'b0;
  bit               post_done = 1'b0;

  // Source queue (FWFT) and tx backpressure, driven just after the falling edge
  always begin
    logic [NBITS-1:0] tmp;
    @(negedge clk);
    #1;
    if (s_pp && src_q.size() > 0) tmp = src_q.pop_front();
    s_em    = (src_q.size() == 0);
    s_out   = s_em ? '0 : src_q[0];
    tx_full = force_full | (bp_mode == 1 && $urandom_range(0, 3) == 0);
  end

  always @(posedge clk) full_seen = tx_full;

  // Monitor: every loaded byte is checked against the head of the scoreboard
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      vectors++;
      if ({s_pp, tx_ld, busy, frame_done, tx_byte} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_outputs got s_pp=%b tx_ld=%b busy=%b frame_done=%b tx_byte=%h want all 0",
                 s_pp, tx_ld, busy, frame_done, tx_byte);
      end
      pops = 0; in_frame = 1'b0; post_done = 1'b0;
    end else begin
      if (post_done) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_gap busy=%b want 0 after frame_done", busy);
        end
        post_done = 1'b0;
      end
      if (s_pp === 1'b1) pops++;
      if (tx_ld === 1'b1) begin
        vectors++;
        if (full_seen) begin
          miscompares++;
          $display("FAIL tx_ld_while_full got tx_ld=1 want 0 (tx_full was 1)");
        end
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_byte got %h want no load", tx_byte);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (tx_byte !== e[7:0]) begin
            miscompares++;
            $display("FAIL tx_byte got %h want %h", tx_byte, e[7:0]);
          end
          vectors++;
          if (frame_done !== e[8]) begin
            miscompares++;
            $display("FAIL frame_done_align got %b want %b (byte %h)", frame_done, e[8], e[7:0]);
          end
          if (e[9]) in_frame = 1'b1;
          if (e[8]) begin
            in_frame = 1'b0; post_done = 1'b1;
            vectors++;
            if (pops != int'(NSAMP)) begin
              miscompares++;
              $display("FAIL pop_count got %0d want %0d", pops, NSAMP);
            end
            pops = 0;
          end
        end
      end else if (frame_done === 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL frame_done_without_load got frame_done=1 want 0");
      end
      if (in_frame) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_hold got %b want 1 mid-frame", busy);
        end
      end
    end
    if (to_cnt != to_seen) begin
      vectors++; miscompares++;
      $display("FAIL wait_timeout got no DUT event want one (timeout #%0d)", to_seen + 1);
      to_seen++;
    end
    if (end_req && !end_done) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL leftover_bytes got %0d unsent want 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // Reference model: one frame built straight from the frame format rules
  task automatic expect_frame(input logic [3:0] ch);
    logic [7:0]  x, b;
    logic [15:0] v;
    exp_q.push_back({1'b1, 1'b0, SYNC});
    b = {ch, m_seq};
    x = b;
    exp_q.push_back({2'b00, b});
    for (int i = 0; i < int'(NSAMP); i++) begin
      v = 16'(stim[i]);
      exp_q.push_back({2'b00, v[15:8]});
      exp_q.push_back({1'b0, (i == int'(NSAMP) - 1) && !CSUM_ON, v[7:0]});
      x = x ^ v[15:8] ^ v[7:0];
    end
    if (CSUM_ON) exp_q.push_back({2'b01, x});
    m_seq = m_seq + 4'd1;
  endtask

  task automatic randomize_stim();
    for (int i = 0; i < int'(NSAMP); i++) stim[i] = NBITS'($urandom);
  endtask

  task automatic wait_pop(input int max);
    bit got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      got = (s_pp === 1'b1);
    end
    if (!got) to_cnt++;
  endtask

  task automatic wait_done(input int max);
    bit got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      @(negedge clk);
      got = (frame_done === 1'b1);
    end
    if (!got) to_cnt++;
  endtask

  // mode 0: all samples ready; 1: source underflows after the first sample; 2: 5-cycle stall in SHI
  task automatic run_frame(input logic [3:0] ch, input int mode);
    ch_id = ch;
    expect_frame(ch);
    if (mode == 1) src_q.push_back(stim[0]);
    else for (int i = 0; i < int'(NSAMP); i++) src_q.push_back(stim[i]);
    en = 1'b1;
    if (mode == 1) begin
      wait_pop(200);
      repeat (20) @(negedge clk);
      for (int i = 1; i < int'(NSAMP); i++) src_q.push_back(stim[i]);
    end else if (mode == 2) begin
      wait_pop(200);
      force_full = 1'b1;
      repeat (5) @(negedge clk);
      force_full = 1'b0;
    end
    wait_done(400);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    stim[0] = 12'h123; stim[1] = 12'hABC;
    run_frame(4'd3, 0);
    repeat (3) @(negedge clk);
    run_frame(4'd3, 2);
    stim[0] = NBITS'($urandom); stim[1] = 12'h0FF;
    run_frame(4'd5, 1);

    // Back-to-back frames through a full seq wrap under random backpressure
    bp_mode = 1;
    for (int f = 0; f < 17; f++) begin
      randomize_stim();
      run_frame(4'd0, 0);
    end

    // en drops during the second sample: frame must finish, then nothing starts
    randomize_stim();
    ch_id = 4'd9;
    expect_frame(ch_id);
    for (int i = 0; i < int'(NSAMP); i++) src_q.push_back(stim[i]);
    en = 1'b1;
    wait_pop(200);
    wait_pop(200);
    en = 1'b0;
    wait_done(400);
    randomize_stim();
    for (int i = 0; i < int'(NSAMP); i++) src_q.push_back(stim[i]);
    repeat (30) @(negedge clk);
    expect_frame(ch_id);
    en = 1'b1;
    wait_done(400);

    // Asynchronous reset mid-frame, checked before the next rising edge
    randomize_stim();
    ch_id = 4'($urandom);
    repeat (3) @(negedge clk);
    expect_frame(ch_id);
    for (int i = 0; i < int'(NSAMP); i++) src_q.push_back(stim[i]);
    repeat ($urandom_range(2, 9)) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    exp_q.delete();
    src_q.delete();
    m_seq = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    repeat (12) @(negedge clk);

    for (int f = 0; f < 4; f++) begin
      randomize_stim();
      run_frame(4'($urandom), 0);
    end

    bp_mode = 0;
    repeat (5) @(negedge clk);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
